// File: rtl/prince_pkg.sv
// prince_pkg: round constants, state type and the SR^-1 / M' linear-layer functions
// shared by the masked PRINCE inverse linear stage.
package prince_pkg;
  localparam int SHARE_W = 64;
  localparam int NRC = 5;
  localparam logic [SHARE_W-1:0] RC [NRC] = '{
    64'h7ef84f78fd955cb1,
    64'h85840851f1ac43aa,
    64'hc882d32f25323c54,
    64'h64a51195e0e3610d,
    64'hd3b5a399ca0c2399
  };
  typedef enum logic {IDLE, RUN} state_t;
  // nibble 0 is bits [63:60]; output nibble j takes input nibble 13*j mod 16
  function automatic logic [SHARE_W-1:0] sr_inv(input logic [SHARE_W-1:0] x);
    logic [SHARE_W-1:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[63-4*j -: 4] = x[63-4*((13*j)%16) -: 4];
    return r;
  endfunction
  // block-circulant 4x4 of M0..M3, where Mk drops nibble bit k (bit 0 = nibble MSB)
  function automatic logic [15:0] m_hat(input logic [15:0] x, input int off);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[15-4*i -: 4] = r[15-4*i -: 4] ^ (x[15-4*j -: 4] & ~(4'b1000 >> ((i + j + off) % 4)));
    return r;
  endfunction
  function automatic logic [15:0] m_hat0(input logic [15:0] x);
    return m_hat(x, 0);
  endfunction
  function automatic logic [15:0] m_hat1(input logic [15:0] x);
    return m_hat(x, 1);
  endfunction
  function automatic logic [SHARE_W-1:0] m_prime(input logic [SHARE_W-1:0] x);
    return {m_hat0(x[63:48]), m_hat1(x[47:32]), m_hat1(x[31:16]), m_hat0(x[15:0])};
  endfunction
endpackage

// File: rtl/prince_lin_share.sv
// prince_lin_share: combinational SR^-1 followed by M' on a single 64-bit share.
module prince_lin_share
  import prince_pkg::*;
(
  input  logic [SHARE_W-1:0] din,
  output logic [SHARE_W-1:0] dout
);
  assign dout = m_prime(sr_inv(din));
endmodule

// File: rtl/prince_inv_lin_stage.sv
// prince_inv_lin_stage: registered 3-share masked linear stage of a PRINCE inverse round,
// injecting k1^RC into share 0 and sequencing RC6..RC10 with a round counter.
module prince_inv_lin_stage
  import prince_pkg::*;
#(
  parameter int NSHARES = 3,
  parameter int NROUNDS = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_first,
  input  logic [SHARE_W-1:0]         k1,
  input  logic [SHARE_W*NSHARES-1:0] din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [SHARE_W*NSHARES-1:0] dout,
  output logic                       seq_err
);
  localparam int RW = NROUNDS > 1 ? $clog2(NROUNDS) : 1;
  localparam logic [RW-1:0] LAST = RW'(NROUNDS - 1);
  state_t state, state_nx;
  logic [RW-1:0] rnd, rnd_nx, idx;
  logic accept, last_nx, err_nx;
  logic [SHARE_W*NSHARES-1:0] t, u;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign idx = in_first ? '0 : rnd;
  always_comb begin
    state_nx = state;
    rnd_nx = rnd;
    last_nx = 1'b0;
    err_nx = 1'b0;
    if (accept && (in_first || state == RUN)) begin
      last_nx = idx == LAST;
      state_nx = last_nx ? IDLE : RUN;
      rnd_nx = last_nx ? '0 : idx + RW'(1);
    end else if (accept) begin
      err_nx = 1'b1;
    end
  end
  // only share 0 ever sees the key and round constant
  always_comb begin
    t = din;
    t[SHARE_W-1:0] = din[SHARE_W-1:0] ^ k1 ^ RC[idx];
  end
  for (genvar s = 0; s < NSHARES; s++) begin : g_share
    prince_lin_share u_share (
      .din (t[SHARE_W*s +: SHARE_W]),
      .dout(u[SHARE_W*s +: SHARE_W])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rnd <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      dout <= '0;
      seq_err <= 1'b0;
    end else begin
      state <= state_nx;
      rnd <= rnd_nx;
      seq_err <= seq_err | err_nx;
      if (accept) begin
        out_valid <= 1'b1;
        out_last <= last_nx;
        dout <= u;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_prince_inv_lin_stage.sv
// tb_prince_inv_lin_stage: random and directed stimulus against a bit-level
// reference of SR^-1 and M' plus a round-sequencing scoreboard.
module tb_prince_inv_lin_stage;
  localparam int NS = 3;
  localparam int W = 64 * NS;
  localparam logic [63:0] RCT [5] = '{
    64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa, 64'hc882d32f25323c54,
    64'h64a51195e0e3610d, 64'hd3b5a399ca0c2399
  };
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_first, out_valid, out_ready, out_last, seq_err;
  logic [63:0] k1;
  logic [W-1:0] din, dout;
  int errors = 0, checks = 0, beats = 0;
  bit started = 1'b0;
  bit m_valid = 1'b0, m_last = 1'b0, m_err = 1'b0, m_run = 1'b0;
  int m_rnd = 0;
  logic [W-1:0] m_dout = '0;
  logic [63:0] m_plain = '0;

  always #5 clk = ~clk;

  prince_inv_lin_stage #(.NSHARES(NS), .NROUNDS(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .k1(k1), .din(din), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .dout(dout), .seq_err(seq_err)
  );

  function automatic logic [63:0] ref_sr_inv(input logic [63:0] x);
    logic [63:0] r = '0;
    for (int j = 0; j < 16; j++) r = (r << 4) | 64'((x >> (4 * (15 - (13 * j) % 16))) & 64'hf);
    return r;
  endfunction

  function automatic logic [63:0] ref_sr(input logic [63:0] x);
    logic [63:0] r = '0;
    for (int j = 0; j < 16; j++) r = (r << 4) | 64'((x >> (4 * (15 - (5 * j) % 16))) & 64'hf);
    return r;
  endfunction

  // bit q counts from the MSB; the block (i,j) of column c is diagonal with bit k cleared
  function automatic logic [63:0] ref_mprime(input logic [63:0] x);
    logic [63:0] r = '0;
    for (int q = 0; q < 64; q++) begin
      int c = q / 16, i = (q % 16) / 4, b = q % 4;
      int off = (c == 1 || c == 2) ? 1 : 0;
      for (int j = 0; j < 4; j++)
        if ((i + j + off) % 4 != b) r[63-q] = r[63-q] ^ x[63-(16*c+4*j+b)];
    end
    return r;
  endfunction

  function automatic logic [63:0] lin(input logic [63:0] x);
    return ref_mprime(ref_sr_inv(x));
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] rndw();
    logic [W-1:0] r = '0;
    for (int i = 0; i < NS; i++) r[64*i +: 64] = rnd64();
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: block position and expected registers, updated on each edge
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_last = 1'b0; m_err = 1'b0; m_run = 1'b0; m_rnd = 0; m_dout = '0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      int r;
      logic [63:0] sh, pl;
      r = in_first ? 0 : m_rnd;
      if (!in_first && !m_run) m_err = 1'b1;
      pl = '0;
      for (int s = 0; s < NS; s++) begin
        sh = din[64*s +: 64] ^ (s == 0 ? k1 ^ RCT[r] : 64'h0);
        m_dout[64*s +: 64] = lin(sh);
        pl ^= sh;
      end
      m_plain = lin(pl);
      m_last = (in_first || m_run) && r == 4;
      if (in_first || m_run) begin
        m_run = r < 4;
        m_rnd = r < 4 ? r + 1 : 0;
      end
      m_valid = 1'b1;
      beats++;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [63:0] x;
      chk("out_valid", W'(out_valid), W'(m_valid));
      chk("in_ready", W'(in_ready), W'(!m_valid || out_ready));
      chk("out_last", W'(out_last), W'(m_last));
      chk("seq_err", W'(seq_err), W'(m_err));
      chk("dout", dout, m_dout);
      if (m_valid) begin
        x = '0;
        for (int s = 0; s < NS; s++) x ^= dout[64*s +: 64];
        chk("share_xor", W'(x), W'(m_plain));
      end
    end
  end

  initial begin
    logic [63:0] c;
    logic [W-1:0] d, din2;
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; k1 = '0; din = '0; out_ready = 1'b1;
    step();
    step();
    chk("reset_valid", W'(out_valid), W'(0));
    chk("reset_dout", dout, '0);
    chk("reset_err", W'(seq_err), W'(0));
    started = 1'b1;
    rst_n = 1'b1;
    chk("pin_sr_inv", W'(ref_sr_inv(64'h0123456789abcdef)), W'(64'h0da741eb852fc963));
    chk("pin_sr", W'(ref_sr(ref_sr_inv(64'h0123456789abcdef))), W'(64'h0123456789abcdef));
    chk("pin_m_col0", W'(ref_mprime(64'h8000000000000000)), W'(64'h0888000000000000));
    chk("pin_m_col1", W'(ref_mprime(64'h0000800000000000)), W'(64'h0000888000000000));
    chk("pin_lin", W'(lin(64'h0123456789abcdef)), W'(64'h70dac963852fb41e));
    for (int i = 0; i < 4; i++) begin
      c = rnd64();
      chk("pin_m_invol", W'(ref_mprime(ref_mprime(c))), W'(c));
    end
    // key cancels RC6 in share 0
    k1 = RCT[0]; din = '0; in_first = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("keycancel_dout", dout, '0);
    chk("keycancel_last", W'(out_last), W'(0));
    chk("keycancel_valid", W'(out_valid), W'(1));
    // share independence, restart mid-block
    k1 = '0; din = {64'h0123456789abcdef, 64'h0123456789abcdef, 64'h0}; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("indep_s1", W'(dout[127:64]), W'(64'h70dac963852fb41e));
    chk("indep_s2", W'(dout[191:128]), W'(64'h70dac963852fb41e));
    chk("indep_s0", W'(dout[63:0]), W'(lin(RCT[0])));
    chk("indep_err", W'(seq_err), W'(0));
    c = dout[127:64];
    din = {64'h0, c, 64'h0}; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("involution", W'(ref_mprime(dout[127:64])), W'(ref_sr_inv(c)));
    // five back-to-back rounds
    din = '0; in_valid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      in_first = (b == 0);
      step();
      chk("seq_valid", W'(out_valid), W'(1));
      chk("seq_last", W'(out_last), W'(b == 4));
      chk("seq_s0", W'(dout[63:0]), W'(lin(RCT[b])));
    end
    in_valid = 1'b0;
    step();
    // backpressure then same-edge replacement
    k1 = rnd64(); din = rndw(); in_first = 1'b1; in_valid = 1'b1;
    step();
    out_ready = 1'b0; d = dout; din2 = rndw(); din = din2; in_first = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", dout, d);
      chk("bp_ready", W'(in_ready), W'(0));
      chk("bp_valid", W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_replace", W'(dout[63:0]), W'(lin(din2[63:0] ^ k1 ^ RCT[1])));
    chk("bp_replace_valid", W'(out_valid), W'(1));
    // reset mid-block, then an un-started beat
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_valid", W'(out_valid), W'(0));
    chk("midrst_dout", dout, '0);
    chk("midrst_last", W'(out_last), W'(0));
    k1 = '0; din = '0; in_first = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("err_set", W'(seq_err), W'(1));
    chk("err_rc6", W'(dout[63:0]), W'(lin(RCT[0])));
    step();
    chk("err_sticky", W'(seq_err), W'(1));
    in_first = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("restart_rc6", W'(dout[63:0]), W'(lin(RCT[0])));
    // random traffic
    beats = 0;
    for (int cyc = 0; cyc < 40000 && beats < 5000; cyc++) begin
      rst_n = $urandom_range(0, 999) != 0;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      in_first = m_run ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 9) != 0);
      if (in_first) k1 = rnd64();
      din = rndw();
      step();
    end
    checks++;
    if (beats < 5000) begin
      errors++;
      $display("FAIL random_budget: got %0d beats expected 5000", beats);
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
